// File: rtl/ines_loader.sv
// ines_loader: streams an iNES (mapper 0) image into the cartridge memories.
// The 16-byte header is validated and its geometry fields are latched. PRG
// bytes then go to the 32 KiB PRG port and CHR bytes to the 8 KiB CHR port.
// Each write is registered, so the strobe lands one cycle after the accept.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// HEADER | consuming and checking header bytes 0..15
// PRG    | writing PRG bytes at address = byte counter
// CHR    | writing CHR bytes at address = byte counter[12:0]
// DONE   | image complete, source stalled until the next start
// ERR    | header rejected, source stalled until the next start
module ines_loader (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prg_wr_en,
  output logic [14:0] prg_addr,
  output logic [7:0]  prg_din,
  output logic        chr_wr_en,
  output logic [12:0] chr_addr,
  output logic [7:0]  chr_din,
  output logic [7:0]  prg_banks,
  output logic [7:0]  chr_banks,
  output logic        mirroring,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PRG,
    S_CHR,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [7:0]  prg_banks_q, prg_banks_d;
  logic [7:0]  chr_banks_q, chr_banks_d;
  logic        mirroring_q, mirroring_d;
  logic        prg_we_q, prg_we_d;
  logic [14:0] prg_addr_q, prg_addr_d;
  logic [7:0]  prg_din_q, prg_din_d;
  logic        chr_we_q, chr_we_d;
  logic [12:0] chr_addr_q, chr_addr_d;
  logic [7:0]  chr_din_q, chr_din_d;

  logic        accept;
  logic        hdr_bad;
  logic [14:0] prg_last;

  // A restart wins over a same-cycle byte, which is then silently dropped.
  assign in_ready = (state_q == S_HEADER) || (state_q == S_PRG) || (state_q == S_CHR);
  assign accept   = in_valid & in_ready & ~start;

  // Only 1 or 2 PRG banks can ever reach the PRG state.
  assign prg_last = (prg_banks_q == 8'd2) ? 15'h7FFF : 15'h3FFF;

  // Header byte check, indexed by the position of the byte being offered.
  always_comb begin
    hdr_bad = 1'b0;
    case (cnt_q[3:0])
      4'd0:    hdr_bad = (in_data != 8'h4E);
      4'd1:    hdr_bad = (in_data != 8'h45);
      4'd2:    hdr_bad = (in_data != 8'h53);
      4'd3:    hdr_bad = (in_data != 8'h1A);
      4'd4:    hdr_bad = (in_data != 8'd1) && (in_data != 8'd2);
      4'd5:    hdr_bad = (in_data > 8'd1);
      4'd6:    hdr_bad = in_data[2];
      default: hdr_bad = 1'b0;
    endcase
  end

  // Next-state, counter, header latches and registered write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prg_banks_d = prg_banks_q;
    chr_banks_d = chr_banks_q;
    mirroring_d = mirroring_q;
    prg_we_d    = 1'b0;
    prg_addr_d  = prg_addr_q;
    prg_din_d   = prg_din_q;
    chr_we_d    = 1'b0;
    chr_addr_d  = chr_addr_q;
    chr_din_d   = chr_din_q;

    if (start) begin
      state_d     = S_HEADER;
      cnt_d       = '0;
      prg_banks_d = '0;
      chr_banks_d = '0;
      mirroring_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_HEADER: begin
          // Geometry fields are latched even when rejected, for diagnosis.
          if (cnt_q[3:0] == 4'd4) prg_banks_d = in_data;
          if (cnt_q[3:0] == 4'd5) chr_banks_d = in_data;
          if (cnt_q[3:0] == 4'd6) mirroring_d = in_data[0];
          if (hdr_bad) begin
            state_d = S_ERR;
            cnt_d   = '0;
          end else if (cnt_q[3:0] == 4'd15) begin
            state_d = S_PRG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 15'd1;
          end
        end
        S_PRG: begin
          prg_we_d   = 1'b1;
          prg_addr_d = cnt_q;
          prg_din_d  = in_data;
          if (cnt_q == prg_last) begin
            state_d = (chr_banks_q == 8'd1) ? S_CHR : S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 15'd1;
          end
        end
        S_CHR: begin
          chr_we_d   = 1'b1;
          chr_addr_d = cnt_q[12:0];
          chr_din_d  = in_data;
          if (cnt_q == 15'h1FFF) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 15'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers; memory contents are outside this block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prg_banks_q <= '0;
      chr_banks_q <= '0;
      mirroring_q <= 1'b0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= '0;
      prg_din_q   <= '0;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= '0;
      chr_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prg_banks_q <= prg_banks_d;
      chr_banks_q <= chr_banks_d;
      mirroring_q <= mirroring_d;
      prg_we_q    <= prg_we_d;
      prg_addr_q  <= prg_addr_d;
      prg_din_q   <= prg_din_d;
      chr_we_q    <= chr_we_d;
      chr_addr_q  <= chr_addr_d;
      chr_din_q   <= chr_din_d;
    end
  end

  assign prg_wr_en = prg_we_q;
  assign prg_addr  = prg_addr_q;
  assign prg_din   = prg_din_q;
  assign chr_wr_en = chr_we_q;
  assign chr_addr  = chr_addr_q;
  assign chr_din   = chr_din_q;
  assign prg_banks = prg_banks_q;
  assign chr_banks = chr_banks_q;
  assign mirroring = mirroring_q;
  // DONE and ERR are distinct states, so done and error are exclusive.
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

endmodule
